// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream (16-bit word-count
// header followed by big-endian 32-bit words) into instruction-memory writes
// for the core, holding the core in reset until the image is complete.
//
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   load_req        start a new load (honoured in IDLE or RUN only)
//   in_data/in_valid/in_ready   byte stream in; no back-pressure while loading
//   W_Ins/W_Addr/WE instruction write port to the core (WE is a 1-cycle strobe)
//   CPU_RST         registered reset to the core, low only in RUN
//   busy            high while a header or data bytes are being consumed
//   err             sticky: header length exceeded DEPTH_WORDS
//   words_loaded    count of WE strobes issued by the current/last load
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8,
  parameter bit BOOT_RUN    = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_req,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       W_Ins,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              WE,
  output logic              CPU_RST,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_RUN  = 3'd4
  } state_t;

  localparam state_t      ST_RST  = BOOT_RUN ? ST_RUN : ST_IDLE;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_in_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_load_start;
  logic [15:0]       w_len_full;
  logic              w_word_done;
  logic              w_last_word;
  logic              w_in_range;

  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [23:0]       r_asm;      // first three bytes of the word in flight
  logic [1:0]        r_bidx;
  logic [15:0]       r_widx;     // words received, including dropped ones
  logic [31:0]       r_wins;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic              r_cpu_rst;
  logic              r_err;
  logic [15:0]       r_words;

  assign w_accept     = in_valid & w_in_ready;
  assign w_load_start = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && load_req;
  assign w_len_full   = {r_len_hi, in_data};
  assign w_word_done  = (r_state == ST_DATA) && w_accept && (r_bidx == 2'd3);
  assign w_last_word  = w_word_done && ((r_widx + 16'd1) == r_len);
  // Words beyond memory capacity are drained from the stream but never written.
  assign w_in_range   = ({1'b0, r_widx} < DEPTH_L);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_RST;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: if (load_req) w_state_nxt = ST_HDR0;
      ST_HDR0:         if (w_accept) w_state_nxt = ST_HDR1;
      ST_HDR1:         if (w_accept) w_state_nxt = (w_len_full == 16'd0) ? ST_RUN : ST_DATA;
      ST_DATA:         if (w_last_word) w_state_nxt = ST_RUN;
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_HDR0, ST_HDR1, ST_DATA: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // Datapath: header capture, word assembly, write strobe and counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_len_hi  <= '0;
      r_len     <= '0;
      r_asm     <= '0;
      r_bidx    <= '0;
      r_widx    <= '0;
      r_wins    <= '0;
      r_waddr   <= '0;
      r_we      <= 1'b0;
      r_cpu_rst <= ~BOOT_RUN;
      r_err     <= 1'b0;
      r_words   <= '0;
    end else begin
      r_we <= 1'b0;
      // Release only once RUN has been held for a cycle, so the final WE
      // lands while the core is still in reset; leaving RUN re-asserts at once.
      r_cpu_rst <= ~((r_state == ST_RUN) && (w_state_nxt == ST_RUN));
      if (w_load_start) begin
        r_bidx  <= '0;
        r_widx  <= '0;
        r_waddr <= '0;
        r_err   <= 1'b0;
        r_words <= '0;
      end else begin
        if (r_we) r_waddr <= r_waddr + ADDR_W'(1);
        if (w_accept) begin
          case (r_state)
            ST_HDR0: r_len_hi <= in_data;
            ST_HDR1: begin
              r_len <= w_len_full;
              if ({1'b0, w_len_full} > DEPTH_L) r_err <= 1'b1;
            end
            ST_DATA: begin
              r_bidx <= r_bidx + 2'd1;
              r_asm  <= {r_asm[15:0], in_data};
              if (r_bidx == 2'd3) begin
                r_widx <= r_widx + 16'd1;
                if (w_in_range) begin
                  r_wins  <= {r_asm, in_data};
                  r_we    <= 1'b1;
                  r_words <= r_words + 16'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = w_busy;
  assign W_Ins        = r_wins;
  assign W_Addr       = r_waddr;
  assign WE           = r_we;
  assign CPU_RST      = r_cpu_rst;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: small-capacity instance (4 words) as the
// main target, plus a default-size BOOT_RUN instance sharing the same inputs.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        load_req;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready;
  logic [31:0] W_Ins;
  logic [1:0]  W_Addr;
  logic        WE;
  logic        CPU_RST;
  logic        busy;
  logic        err;
  logic [15:0] words_loaded;

  logic        b_in_ready;
  logic [31:0] b_W_Ins;
  logic [7:0]  b_W_Addr;
  logic        b_WE;
  logic        b_CPU_RST;
  logic        b_busy;
  logic        b_err;
  logic [15:0] b_words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_ins [$];
  int          q_addr [$];
  int          acc_cnt = 0;
  int          qb;
  int          ab;

  logic [7:0] t2_bytes [0:9] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                 8'h01, 8'h09, 8'h50, 8'h20};

  always #5 CLK = ~CLK;

  imem_loader #(.DEPTH_WORDS(4), .ADDR_W(2), .BOOT_RUN(1'b0)) u_dut (
    .CLK(CLK), .RST(RST), .load_req(load_req), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .W_Ins(W_Ins), .W_Addr(W_Addr),
    .WE(WE), .CPU_RST(CPU_RST), .busy(busy), .err(err),
    .words_loaded(words_loaded)
  );

  imem_loader #(.DEPTH_WORDS(256), .ADDR_W(8), .BOOT_RUN(1'b1)) u_boot (
    .CLK(CLK), .RST(RST), .load_req(load_req), .in_data(in_data),
    .in_valid(in_valid), .in_ready(b_in_ready), .W_Ins(b_W_Ins), .W_Addr(b_W_Addr),
    .WE(b_WE), .CPU_RST(b_CPU_RST), .busy(b_busy), .err(b_err),
    .words_loaded(b_words_loaded)
  );

  // Write-port and accepted-byte monitor for the main instance
  always @(negedge CLK) begin
    if (WE) begin
      q_ins.push_back(W_Ins);
      q_addr.push_back(int'(W_Addr));
    end
    if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (gap) step();
  endtask

  task automatic start_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  // Two-word program: expect writes 0x20080005@0 then 0x01095020@1
  task automatic chk_two(input string tag, input int base);
    chk({tag, "_nwe"}, 32'(q_ins.size() - base), 32'd2);
    if (q_ins.size() >= base + 2) begin
      chk({tag, "_a0"}, 32'(q_addr[base]),       32'd0);
      chk({tag, "_i0"}, q_ins[base],             32'h20080005);
      chk({tag, "_a1"}, 32'(q_addr[base + 1]),   32'd1);
      chk({tag, "_i1"}, q_ins[base + 1],         32'h01095020);
    end
  endtask

  initial begin
    // T1: reset, bytes presented while not loading are ignored
    RST = 1'b1; load_req = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) step();
    chk("rst_cpu_rst",  32'(CPU_RST),      32'd1);
    chk("rst_we",       32'(WE),           32'd0);
    chk("rst_in_ready", 32'(in_ready),     32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_err",      32'(err),          32'd0);
    chk("rst_words",    32'(words_loaded), 32'd0);
    chk("rst_waddr",    32'(W_Addr),       32'd0);
    chk("rst_wins",     W_Ins,             32'd0);
    chk("boot_cpu_rst", 32'(b_CPU_RST),    32'd0);
    chk("boot_ready",   32'(b_in_ready),   32'd0);
    RST = 1'b0;
    repeat (2) step();
    chk("idle_busy",    32'(busy),         32'd0);
    chk("idle_ready",   32'(in_ready),     32'd0);
    chk("idle_cpu_rst", 32'(CPU_RST),      32'd1);
    chk("idle_acc",     32'(acc_cnt),      32'd0);
    in_valid = 1'b0;

    // T2: two-word load, back-to-back bytes
    qb = q_ins.size();
    start_load();
    chk("t2_busy",  32'(busy),     32'd1);
    chk("t2_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) send(t2_bytes[i], 0);
    chk("t2_last_we",     32'(WE),      32'd1);
    chk("t2_last_addr",   32'(W_Addr),  32'd1);
    chk("t2_last_ins",    W_Ins,        32'h01095020);
    chk("t2_cpu_rst_we",  32'(CPU_RST), 32'd1);
    chk("t2_busy_done",   32'(busy),    32'd0);
    step();
    chk("t2_cpu_rst_rel", 32'(CPU_RST),      32'd0);
    chk("t2_we_pulse",    32'(WE),           32'd0);
    chk("t2_words",       32'(words_loaded), 32'd2);
    chk("t2_waddr_next",  32'(W_Addr),       32'd2);
    chk_two("t2", qb);
    chk("t2_boot_words",  32'(b_words_loaded), 32'd2);

    // T3: empty image, load requested from RUN
    qb = q_ins.size();
    start_load();
    chk("t3_cpu_rst_re", 32'(CPU_RST),      32'd1);
    chk("t3_words_clr",  32'(words_loaded), 32'd0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("t3_busy",      32'(busy),    32'd0);
    chk("t3_cpu_rst_1", 32'(CPU_RST), 32'd1);
    step();
    chk("t3_cpu_rst_0", 32'(CPU_RST), 32'd0);
    chk("t3_nwe",       32'(q_ins.size() - qb), 32'd0);

    // T4: 6-word header into 4-word memory
    qb = q_ins.size();
    ab = acc_cnt;
    start_load();
    send(8'h00, 0);
    send(8'h06, 0);
    chk("t4_err", 32'(err), 32'd1);
    for (int k = 0; k < 6; k++) begin
      send(8'h10 + 8'(k), 0);
      send(8'h20 + 8'(k), 0);
      send(8'h30 + 8'(k), 0);
      send(8'h40 + 8'(k), 0);
    end
    chk("t4_acc",   32'(acc_cnt - ab),      32'd26);
    chk("t4_busy",  32'(busy),              32'd0);
    chk("t4_nwe",   32'(q_ins.size() - qb), 32'd4);
    if (q_ins.size() >= qb + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t4_addr", 32'(q_addr[qb + k]), 32'(k));
        chk("t4_ins",  q_ins[qb + k],
            {8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k), 8'h40 + 8'(k)});
      end
    end
    chk("t4_words", 32'(words_loaded), 32'd4);
    step();
    chk("t4_err_sticky",  32'(err),     32'd1);
    chk("t4_cpu_rst_0",   32'(CPU_RST), 32'd0);
    chk("t4_boot_err",    32'(b_err),   32'd0);
    chk("t4_boot_words",  32'(b_words_loaded), 32'd6);

    // T5: reset mid-load after 6 data bytes, then a fresh load
    qb = q_ins.size();
    start_load();
    chk("t5_err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 8; i++) send(t2_bytes[i], 0);
    RST = 1'b1;
    step();
    chk("t5_rst_we",      32'(WE),           32'd0);
    chk("t5_rst_busy",    32'(busy),         32'd0);
    chk("t5_rst_cpu_rst", 32'(CPU_RST),      32'd1);
    chk("t5_rst_words",   32'(words_loaded), 32'd0);
    chk("t5_rst_waddr",   32'(W_Addr),       32'd0);
    RST = 1'b0;
    repeat (2) step();
    chk("t5_partial_nwe", 32'(q_ins.size() - qb), 32'd1);
    qb = q_ins.size();
    start_load();
    for (int i = 0; i < 10; i++) send(t2_bytes[i], 0);
    step();
    chk_two("t5", qb);
    chk("t5_cpu_rst_0", 32'(CPU_RST), 32'd0);

    // T6: reload from RUN with one byte every three cycles
    qb = q_ins.size();
    start_load();
    chk("t6_cpu_rst_re", 32'(CPU_RST), 32'd1);
    for (int i = 0; i < 10; i++) send(t2_bytes[i], 2);
    chk_two("t6", qb);
    chk("t6_words",     32'(words_loaded), 32'd2);
    chk("t6_cpu_rst_0", 32'(CPU_RST),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
